// File: rtl/mem_arb_pkg.sv
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and constants for the instruction/data memory
//                arbiter (FSM states, owner encoding, word size).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int WORD_BYTES = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Winner selection and last-owner register. The policy is
//                chosen by MEM_ARB_ROUND_ROBIN_EN (defined: alternate on
//                contention; undefined: data port always wins contention).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t winner,
    output owner_t owner
);

    owner_t r_owner;
    owner_t w_winner;

    // The last-served owner doubles as the owner of the running transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_I;
        end else if (grant) begin
            r_owner <= w_winner;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        w_winner = OWN_D;
        if (i_req && d_req) begin
            w_winner = (r_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (i_req) begin
            w_winner = OWN_I;
        end
    end
`else
    always_comb begin
        w_winner = OWN_D;
        if (i_req && !d_req) begin
            w_winner = OWN_I;
        end
    end
`endif

    assign winner = w_winner;
    assign owner  = r_owner;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (instruction refill / data cache) block-transfer
//                arbiter onto a single main-memory port. Arbitration policy
//                selected by MEM_ARB_ROUND_ROBIN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [ADDR_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [ADDR_W-1:0] d_rdata,
    output logic              d_wnext,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [ADDR_W-1:0] mem_read_data,
    input  logic              mem_ready
);

    localparam int c_CNT_W  = $clog2(BLOCK_WORDS);
    localparam int c_BYTE_W = $clog2(WORD_BYTES);
    localparam int c_OFF_W  = c_CNT_W + c_BYTE_W;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0]  c_BASE_MASK =
        ~(ADDR_W'(BLOCK_WORDS * WORD_BYTES) - ADDR_W'(1));

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_write;
    owner_t              w_winner;
    owner_t              w_owner;
    logic                w_grant;
    logic [ADDR_W-1:0]   w_req_addr;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_grant     = (r_state == ST_IDLE) && (i_req || d_req);
    assign w_req_addr  = (w_winner == OWN_D) ? d_addr : i_addr;
    // Base is block-aligned, so the word offset can simply be OR-ed in.
    assign w_word_addr = r_base |
        {{(ADDR_W - c_OFF_W){1'b0}}, r_cnt, {c_BYTE_W{1'b0}}};

    mem_arb_pick u_pick (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant  (w_grant),
        .winner (w_winner),
        .owner  (w_owner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_cnt   <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_base  <= w_req_addr & c_BASE_MASK;
                r_cnt   <= '0;
                r_write <= (w_winner == OWN_D) && d_write;
            end else if ((r_state == ST_XFER) && mem_ready && (r_cnt != c_LAST)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_addr       = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_rvalid       = 1'b0;
        i_rdata        = '0;
        i_done         = 1'b0;
        d_rvalid       = 1'b0;
        d_rdata        = '0;
        d_wnext        = 1'b0;
        d_done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                mem_addr  = w_word_addr;
                mem_read  = !r_write;
                mem_write = r_write;
                if (r_write) begin
                    mem_write_data = d_wdata;
                end
                if (mem_ready) begin
                    if (r_write) begin
                        d_wnext = 1'b1;
                    end else if (w_owner == OWN_D) begin
                        d_rvalid = 1'b1;
                        d_rdata  = mem_read_data;
                    end else begin
                        i_rvalid = 1'b1;
                        i_rdata  = mem_read_data;
                    end
                    if (r_cnt == c_LAST) begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                i_done = (w_owner == OWN_I);
                d_done = (w_owner == OWN_D);
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire
